// File: rtl/byte_tx_sequencer.sv
// rtl/byte_tx_sequencer.sv - byte FIFO feeding a start/8N/stop serial framer
// with latched per-frame bit period and inter-frame gap.
module byte_tx_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 11
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  input  logic [DIV_WIDTH-1:0]          cfg_divisor,
  input  logic [DIV_WIDTH-1:0]          cfg_gap,
  input  logic                          tx_enable,
  input  logic                          clr_overflow,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  assign full     = (count == CW'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign push     = wr_en && !full;
  assign wr_ready = !full;
  assign fifo_count = count;

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && full)     overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  state_t               state, state_n;
  logic [DIV_WIDTH-1:0] cnt, cnt_n;
  logic [DIV_WIDTH-1:0] div_l, div_l_n;
  logic [DIV_WIDTH-1:0] gap_l, gap_l_n;
  logic [7:0]           shift, shift_n;
  logic [2:0]           bit_idx, bit_idx_n;
  logic                 txd_n;
  logic                 bit_done, gap_done, start_ok, load;

  assign bit_done = (cnt == div_l);
  assign gap_done = (cnt == gap_l - DIV_WIDTH'(1));
  assign start_ok = tx_enable && !empty;
  assign pop      = load;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      div_l   <= '0;
      gap_l   <= '0;
      shift   <= '0;
      bit_idx <= '0;
      txd     <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      div_l   <= div_l_n;
      gap_l   <= gap_l_n;
      shift   <= shift_n;
      bit_idx <= bit_idx_n;
      txd     <= txd_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + DIV_WIDTH'(1);
    div_l_n   = div_l;
    gap_l_n   = gap_l;
    shift_n   = shift;
    bit_idx_n = bit_idx;
    load      = 1'b0;

    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start_ok) load = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_n   = DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end else begin
            shift_n   = {1'b0, shift[7:1]};
            bit_idx_n = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          cnt_n = '0;
          if (gap_l != '0)   state_n = GAP;
          else if (start_ok) load = 1'b1;
          else               state_n = IDLE;
        end
      end
      GAP: begin
        if (gap_done) begin
          cnt_n = '0;
          if (start_ok) load = 1'b1;
          else          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase

    // Starting a frame pops the head and snapshots timing for this frame only.
    if (load) begin
      state_n   = START;
      shift_n   = mem[rd_ptr];
      div_l_n   = cfg_divisor;
      gap_l_n   = cfg_gap;
      cnt_n     = '0;
      bit_idx_n = '0;
    end

    // txd is registered from the next state so the line changes on state entry.
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = shift_n[0];
      default: txd_n = 1'b1;
    endcase
  end

endmodule

// File: doc/byte_tx_sequencer.md
# byte_tx_sequencer

Serial transmit sequencer behind the peripheral's APB register block. Bytes pushed by the data-register write strobe are queued in a small FIFO, then framed (start bit, 8 data bits LSB first, stop bit) and shifted out on a single line. Bit period and inter-frame gap come from the two 11-bit configuration registers. The block owns all line timing, so the register file stays purely combinational plus storage.

## Interface
Parameters:
- FIFO_DEPTH, 4, byte-queue entries; power of two, ≥2
- DIV_WIDTH, 11, width of divisor and gap configuration values

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- wr_en  in  1  single-cycle push strobe (data-register write)
- wr_data  in  8  byte to push
- wr_ready  out  1  FIFO not full
- cfg_divisor  in  DIV_WIDTH  bit period minus one, in clk cycles
- cfg_gap  in  DIV_WIDTH  idle-high cycles inserted after each stop bit
- tx_enable  in  1  permits new frames to start
- clr_overflow  in  1  single-cycle clear of overflow
- txd  out  1  serial line, idle high, registered
- busy  out  1  state ≠ IDLE
- fifo_count  out  log2(FIFO_DEPTH)+1  queued bytes
- overflow  out  1  sticky; set when a push is dropped

## Operation
- FIFO: circular, write/read pointers wrap modulo FIFO_DEPTH. Push while full: byte dropped, overflow←1, even if a pop occurs the same cycle. Push while not full and pop in the same cycle: count unchanged, both take effect.
- overflow: set has priority over clr_overflow in the same cycle.
- FSM states: IDLE, START, DATA, STOP, GAP.
- IDLE → START when tx_enable=1 and fifo_count>0. On that edge: pop head into shift register, latch cfg_divisor and cfg_gap into internal copies, clear bit-period counter.
- START: txd=0 for divisor+1 cycles → DATA.
- DATA: txd=shift[0]; after each divisor+1 cycles shift right, bit index +1; after bit 7 → STOP.
- STOP: txd=1 for divisor+1 cycles. At end: if latched gap>0 → GAP; else frame-end decision.
- GAP: txd=1 for latched gap cycles → frame-end decision.
- Frame-end decision: if tx_enable=1 and FIFO non-empty, go directly to START with pop/latch (no IDLE cycle); else IDLE.
- tx_enable deassert mid-frame: current frame, including its gap, completes; no new frame starts.
- Configuration changes mid-frame affect only the next frame.
- Bit-period counter width DIV_WIDTH; counts 0..latched divisor, terminal count = equality, no wrap hazard. Divisor 0 → one cycle per bit.

## Timing
- Reset values: txd=1, busy=0, wr_ready=1, fifo_count=0, overflow=0; FSM IDLE, FIFO emptied. Reset mid-frame: txd returns to 1 asynchronously, queued bytes lost.
- Push visible in fifo_count and wr_ready the cycle after wr_en.
- Earliest start: wr_en in cycle 0 with IDLE/enabled → START entered at edge ending cycle 1; txd=0 from cycle 2.
- Frame length: 10×(D+1) cycles; plus G gap cycles. Back-to-back throughput: one byte per 10×(D+1)+G cycles exactly.
- busy high from START entry through last GAP/STOP cycle; low the cycle IDLE is entered.
- Pop decrements fifo_count on the START-entry edge.

## Test plan
- Reset then push 0xA5, D=3, G=0 → txd low 4 cycles, then bits 1,0,1,0,0,1,0,1 each 4 cycles, stop high 4 cycles; busy high exactly 40 cycles.
- Push 0x00 and 0xFF back-to-back, D=0, G=5 → 10-cycle frames separated by exactly 5 high cycles; no IDLE bubble; fifo_count 2→1→0.
- FIFO_DEPTH=4, tx_enable=0, push 5 bytes → wr_ready low after 4th, 5th dropped, overflow=1, fifo_count=4; clr_overflow → overflow=0 next cycle.
- Change cfg_divisor 3→7 mid-frame → current frame keeps 4-cycle bits; next frame uses 8-cycle bits.
- Deassert tx_enable during DATA of first of two queued bytes → first frame completes, second stays queued (fifo_count=1), busy drops; re-enable → second frame starts.
- Assert rst during DATA → txd=1, busy=0, fifo_count=0 immediately; after release, new push transmits normally.
